// File: rtl/cmem_loader.sv
// cmem_loader: loads host coefficient words MSB-first into the serial-shift coefficient
// memory, with an optional recirculating verify pass checked against an XOR checksum.
package myfilter_pkg;
  localparam int CMEMSIZE = 4;
  localparam int DATABITS = 8;
endpackage

module cmem_loader #(
  parameter int CMEMSIZE = myfilter_pkg::CMEMSIZE,
  parameter int DATABITS = myfilter_pkg::DATABITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  input  logic                verify_en_in,
  input  logic                abort_in,
  input  logic                coef_valid_in,
  input  logic [DATABITS-1:0] coef_in,
  output logic                coef_ready_out,
  output logic                sde_out,
  output logic                sd_out,
  input  logic                sd_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                err_out
);
  localparam int BW = $clog2(DATABITS);
  localparam int WW = $clog2(CMEMSIZE + 1);
  localparam int VW = $clog2(CMEMSIZE * DATABITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHIFT, S_VERIFY, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [DATABITS-1:0] r_shift, r_csum, r_acc, r_deser, w_acc;
  logic [BW-1:0]       r_bit_cnt;
  logic [WW-1:0]       r_word_cnt;
  logic [VW-1:0]       r_ver_cnt;
  logic                r_ver_en, r_err;
  logic                w_bit_last, w_ver_last;

  assign w_bit_last = r_bit_cnt == BW'(DATABITS - 1);
  assign w_ver_last = r_ver_cnt == VW'(CMEMSIZE * DATABITS - 1);
  // Word being completed this cycle, folded in so the final compare sees the whole chain
  assign w_acc = r_acc ^ {r_deser[DATABITS-2:0], sd_in};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start_in ? S_WAIT : S_IDLE;
      S_WAIT:   w_next = abort_in ? S_IDLE : coef_valid_in ? S_SHIFT : S_WAIT;
      S_SHIFT:  w_next = abort_in ? S_IDLE : !w_bit_last ? S_SHIFT :
                         r_word_cnt < WW'(CMEMSIZE) ? S_WAIT : r_ver_en ? S_VERIFY : S_DONE;
      S_VERIFY: w_next = abort_in ? S_IDLE : w_ver_last ? S_DONE : S_VERIFY;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    coef_ready_out = r_state == S_WAIT;
    sde_out        = r_state == S_SHIFT || r_state == S_VERIFY;
    busy_out       = r_state != S_IDLE;
    done_out       = r_state == S_DONE && !r_err;
    err_out        = r_err;
    sd_out         = r_state == S_SHIFT ? r_shift[DATABITS-1] : r_state == S_VERIFY ? sd_in : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shift    <= '0;
      r_csum     <= '0;
      r_acc      <= '0;
      r_deser    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_ver_cnt  <= '0;
      r_ver_en   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start_in) begin
          r_err      <= 1'b0;
          r_csum     <= '0;
          r_acc      <= '0;
          r_word_cnt <= '0;
          r_bit_cnt  <= '0;
          r_ver_cnt  <= '0;
          r_ver_en   <= verify_en_in;
        end
        S_WAIT: if (abort_in) r_err <= 1'b1;
          else if (coef_valid_in) begin
            r_shift    <= coef_in;
            r_csum     <= r_csum ^ coef_in;
            r_word_cnt <= r_word_cnt + 1'b1;
            r_bit_cnt  <= '0;
          end
        S_SHIFT: if (abort_in) r_err <= 1'b1;
          else begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
          end
        S_VERIFY: if (abort_in) r_err <= 1'b1;
          else begin
            r_deser   <= {r_deser[DATABITS-2:0], sd_in};
            r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            r_ver_cnt <= r_ver_cnt + 1'b1;
            if (w_bit_last) r_acc <= w_acc;
            if (w_ver_last && w_acc != r_csum) r_err <= 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cmem_loader.sv
// tb_cmem_loader: drives host loads into cmem_loader against a behavioural shift-chain
// memory; a bit scoreboard checks the serial stream and per-test checks cover the rest.
module tb_cmem_loader;
  localparam int CM = 4;
  localparam int DB = 8;
  localparam int N  = CM * DB;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start_in = 1'b0, verify_en_in = 1'b0, abort_in = 1'b0, coef_valid_in = 1'b0;
  logic [DB-1:0] coef_in = '0;
  logic          coef_ready_out, sde_out, sd_out, sd_in, busy_out, done_out, err_out;
  logic [N-1:0]  mem = '0;
  logic          force_zero = 1'b0, exp_b;
  logic [DB-1:0] words [CM] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic          exp_q [$];
  int checks = 0, errors = 0, sde_cnt = 0, done_cnt = 0;

  cmem_loader #(.CMEMSIZE(CM), .DATABITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .verify_en_in(verify_en_in),
    .abort_in(abort_in), .coef_valid_in(coef_valid_in), .coef_in(coef_in),
    .coef_ready_out(coef_ready_out), .sde_out(sde_out), .sd_out(sd_out), .sd_in(sd_in),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Chain output is the top bit of the highest address
  assign sd_in = force_zero ? 1'b0 : mem[N-1];
  always @(posedge clk) if (sde_out) mem <= {mem[N-2:0], sd_out};

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (sde_out) sde_cnt++;
      if (done_out) done_cnt++;
      if (sde_out && exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        checks++;
        if (sd_out !== exp_b) begin
          errors++;
          $display("FAIL sd_bit got %b exp %b at %0t", sd_out, exp_b, $time);
        end
      end
    end
  endtask

  task automatic start_pulse(input logic ver);
    start_in = 1'b1;
    verify_en_in = ver;
    tick();
    start_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || coef_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_ready got busy=%b ready=%b exp 1 1", busy_out, coef_ready_out);
    end
  endtask

  task automatic send_word(input logic [DB-1:0] w, input int gap);
    int n = 0;
    if (gap > 0) begin
      while (!coef_ready_out && n < 200) begin tick(); n++; end
      repeat (gap) tick();
    end
    coef_valid_in = 1'b1;
    coef_in = w;
    n = 0;
    while (!coef_ready_out && n < 200) begin tick(); n++; end
    if (!coef_ready_out) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout word %h", w);
    end
    for (int i = DB - 1; i >= 0; i--) exp_q.push_back(w[i]);
    tick();
    coef_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 400) begin tick(); n++; end
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b exp 0", busy_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_out, coef_ready_out, sde_out, sd_out, done_out, err_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {busy_out, coef_ready_out, sde_out, sd_out, done_out, err_out});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy_out, coef_ready_out, sde_out, done_out, err_out} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp 00000",
               {busy_out, coef_ready_out, sde_out, done_out, err_out});
    end
  endtask

  task automatic test_load();
    sde_cnt = 0; done_cnt = 0;
    start_pulse(1'b0);
    for (int j = 0; j < CM; j++) send_word(words[j], 0);
    wait_idle();
    for (int a = 0; a < CM; a++) begin
      checks++;
      if (mem[a*DB +: DB] !== words[CM-1-a]) begin
        errors++;
        $display("FAIL load_mem addr %0d got %h exp %h", a, mem[a*DB +: DB], words[CM-1-a]);
      end
    end
    checks++;
    if (sde_cnt !== N || done_cnt !== 1 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL load_counts sde=%0d done=%0d err=%b exp %0d 1 0", sde_cnt, done_cnt, err_out, N);
    end
  endtask

  task automatic test_verify();
    sde_cnt = 0; done_cnt = 0;
    start_pulse(1'b1);
    for (int j = 0; j < CM; j++) send_word(words[j], 0);
    wait_idle();
    for (int a = 0; a < CM; a++) begin
      checks++;
      if (mem[a*DB +: DB] !== words[CM-1-a]) begin
        errors++;
        $display("FAIL verify_mem addr %0d got %h exp %h", a, mem[a*DB +: DB], words[CM-1-a]);
      end
    end
    checks++;
    if (sde_cnt !== 2 * N || done_cnt !== 1 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL verify_counts sde=%0d done=%0d err=%b exp %0d 1 0", sde_cnt, done_cnt, err_out, 2 * N);
    end
  endtask

  task automatic test_verify_fail();
    sde_cnt = 0; done_cnt = 0;
    force_zero = 1'b1;
    start_pulse(1'b1);
    for (int j = 0; j < CM; j++) send_word(words[j], 0);
    wait_idle();
    force_zero = 1'b0;
    checks++;
    if (err_out !== 1'b1 || done_cnt !== 0 || sde_cnt !== 2 * N) begin
      errors++;
      $display("FAIL verify_fail err=%b done=%0d sde=%0d exp 1 0 %0d", err_out, done_cnt, sde_cnt, 2 * N);
    end
  endtask

  task automatic test_gapped();
    sde_cnt = 0; done_cnt = 0;
    mem = '0;
    start_pulse(1'b0);
    send_word(words[0], 0);
    send_word(words[1], 5);
    start_in = 1'b1;
    verify_en_in = 1'b1;
    tick();
    start_in = 1'b0;
    verify_en_in = 1'b0;
    send_word(words[2], 5);
    send_word(words[3], 5);
    wait_idle();
    for (int a = 0; a < CM; a++) begin
      checks++;
      if (mem[a*DB +: DB] !== words[CM-1-a]) begin
        errors++;
        $display("FAIL gapped_mem addr %0d got %h exp %h", a, mem[a*DB +: DB], words[CM-1-a]);
      end
    end
    checks++;
    if (sde_cnt !== N || done_cnt !== 1 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL gapped_counts sde=%0d done=%0d err=%b exp %0d 1 0", sde_cnt, done_cnt, err_out, N);
    end
  endtask

  task automatic test_abort();
    sde_cnt = 0; done_cnt = 0;
    mem = '0;
    start_pulse(1'b0);
    for (int j = 0; j < 3; j++) send_word(words[j], 0);
    tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    exp_q.delete();
    checks++;
    if (sde_out !== 1'b0 || busy_out !== 1'b0 || err_out !== 1'b1 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort sde=%b busy=%b err=%b done=%0d exp 0 0 1 0", sde_out, busy_out, err_out, done_cnt);
    end
    repeat (3) tick();
    start_pulse(1'b0);
    checks++;
    if (err_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_err_clear got %b exp 0", err_out);
    end
    for (int j = 0; j < CM; j++) send_word(words[j], 0);
    wait_idle();
    for (int a = 0; a < CM; a++) begin
      checks++;
      if (mem[a*DB +: DB] !== words[CM-1-a]) begin
        errors++;
        $display("FAIL reload_mem addr %0d got %h exp %h", a, mem[a*DB +: DB], words[CM-1-a]);
      end
    end
    checks++;
    if (done_cnt !== 1 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL reload_done done=%0d err=%b exp 1 0", done_cnt, err_out);
    end
  endtask

  task automatic test_reset_mid_verify();
    int saved;
    sde_cnt = 0; done_cnt = 0;
    start_pulse(1'b1);
    for (int j = 0; j < CM; j++) send_word(words[j], 0);
    repeat (12) tick();
    checks++;
    if (sde_out !== 1'b1 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL in_verify sde=%b busy=%b exp 1 1", sde_out, busy_out);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({busy_out, coef_ready_out, sde_out, sd_out, done_out, err_out} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset got %b exp 000000",
               {busy_out, coef_ready_out, sde_out, sd_out, done_out, err_out});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saved = sde_cnt;
    repeat (10) tick();
    checks++;
    if (busy_out !== 1'b0 || sde_cnt !== saved || done_cnt !== 0) begin
      errors++;
      $display("FAIL post_reset busy=%b sde=%0d done=%0d exp 0 %0d 0", busy_out, sde_cnt, done_cnt, saved);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_verify();
    test_verify_fail();
    test_gapped();
    test_abort();
    test_reset_mid_verify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
